// File: rtl/param_cam.sv
// -----------------------------------------------------------------------------
// param_cam -- parameterised content-addressable memory with a flush engine.
//
// Stores DEPTH words of WIDTH bits, each with a valid bit. Supports indexed
// write, invalidate and read, plus a single-cycle associative search that
// returns the lowest hitting index and a multi-hit flag. A flush_i pulse walks
// through every entry, clearing one valid bit per cycle; while it runs the
// table refuses all other requests.
//
// Build option:
//   PARAM_CAM_TERNARY_EN  defined   -> search_mask_i selects compared bits
//                         undefined -> mask ignored, exact-match binary CAM
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   read_enable_i/read_index_i        read request (result one cycle later)
//   write_enable_i/write_index_i/
//   write_data_i                      write request (sets entry valid)
//   invalidate_enable_i/
//   invalidate_index_i                clear one valid bit
//   flush_i                           start a full-table flush
//   search_enable_i/search_data_i/
//   search_mask_i                     search request (result one cycle later)
//   read_valid_o/read_value_o         registered read result
//   search_valid_o/search_index_o/
//   search_multi_o                    registered search result
//   busy_o                            flush in progress
// -----------------------------------------------------------------------------
module param_cam #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             read_enable_i,
    input  logic [IDX_W-1:0] read_index_i,
    input  logic             write_enable_i,
    input  logic [IDX_W-1:0] write_index_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             invalidate_enable_i,
    input  logic [IDX_W-1:0] invalidate_index_i,
    input  logic             flush_i,
    input  logic             search_enable_i,
    input  logic [WIDTH-1:0] search_data_i,
    input  logic [WIDTH-1:0] search_mask_i,
    output logic             read_valid_o,
    output logic [WIDTH-1:0] read_value_o,
    output logic             search_valid_o,
    output logic [IDX_W-1:0] search_index_o,
    output logic             search_multi_o,
    output logic             busy_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] flush_cnt_q;
    logic             flush_last;
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             wr_ok, inv_ok, rd_ok, srch_ok;
    logic [WIDTH-1:0] eff_mask;
    logic [DEPTH-1:0] hit;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_any, hit_multi;

    logic             read_vld_p1;
    logic [WIDTH-1:0] read_data_p1;
    logic             srch_vld_p1;
    logic [IDX_W-1:0] srch_idx_p1;
    logic             srch_multi_p1;

    assign busy = (state_q == FLUSH);

    // A flush request in the same cycle as a write takes precedence; reads and
    // searches in that cycle still see the table as it was.
    assign wr_ok   = write_enable_i && !busy && !flush_i;
    assign inv_ok  = invalidate_enable_i && !busy;
    assign rd_ok   = read_enable_i && !busy;
    assign srch_ok = search_enable_i && !busy;

`ifdef PARAM_CAM_TERNARY_EN
    assign eff_mask = search_mask_i;
`else
    // Binary CAM: every bit compared; the OR keeps the unused port referenced.
    assign eff_mask = search_mask_i | {WIDTH{1'b1}};
`endif

    // Flush FSM: next-state logic
    always_comb begin
        state_d    = state_q;
        flush_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                flush_last = (flush_cnt_q == IDX_W'(DEPTH - 1));
                if (flush_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (busy) flush_cnt_q <= flush_last ? '0 : flush_cnt_q + IDX_W'(1);
            else      flush_cnt_q <= '0;
        end
    end

    // Valid bits: invalidate applied first so a same-index write wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            if (busy)   valid_q[flush_cnt_q]        <= 1'b0;
            if (inv_ok) valid_q[invalidate_index_i] <= 1'b0;
            if (wr_ok)  valid_q[write_index_i]      <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[write_index_i] <= write_data_i;
    end

    // Match vector and lowest-index priority encode
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i] && (((mem[i] ^ search_data_i) & eff_mask) == '0);
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = IDX_W'(i);
        end
    end

    assign hit_any   = |hit;
    // Clearing the lowest set bit leaves something only if two or more hit.
    assign hit_multi = |(hit & (hit - DEPTH'(1)));

    // Stage p1: registered read and search results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_vld_p1   <= 1'b0;
            read_data_p1  <= '0;
            srch_vld_p1   <= 1'b0;
            srch_idx_p1   <= '0;
            srch_multi_p1 <= 1'b0;
        end else begin
            read_vld_p1   <= rd_ok && valid_q[read_index_i];
            read_data_p1  <= (rd_ok && valid_q[read_index_i]) ? mem[read_index_i] : '0;
            srch_vld_p1   <= srch_ok && hit_any;
            srch_idx_p1   <= (srch_ok && hit_any) ? hit_idx : '0;
            srch_multi_p1 <= srch_ok && hit_multi;
        end
    end

    assign read_valid_o   = read_vld_p1;
    assign read_value_o   = read_data_p1;
    assign search_valid_o = srch_vld_p1;
    assign search_index_o = srch_idx_p1;
    assign search_multi_o = srch_multi_p1;
    assign busy_o         = busy;

endmodule

// File: tb/tb_param_cam.sv
// -----------------------------------------------------------------------------
// tb_param_cam -- self-checking bench for param_cam (WIDTH=32, DEPTH=32).
// Directed table of single-cycle vectors, hand-written flush and reset-during-
// flush sequences, then randomized traffic against a behavioural table model.
// -----------------------------------------------------------------------------
module tb_param_cam;

    localparam int W = 32;
    localparam int D = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          re, we, ie, se, fl;
    logic [IW-1:0] ri, wi, ii;
    logic [W-1:0]  wd, sd, smk;

    logic          read_valid, search_valid, search_multi, busy;
    logic [W-1:0]  read_value;
    logic [IW-1:0] search_index;

    param_cam #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .read_enable_i      (re),
        .read_index_i       (ri),
        .write_enable_i     (we),
        .write_index_i      (wi),
        .write_data_i       (wd),
        .invalidate_enable_i(ie),
        .invalidate_index_i (ii),
        .flush_i            (fl),
        .search_enable_i    (se),
        .search_data_i      (sd),
        .search_mask_i      (smk),
        .read_valid_o       (read_valid),
        .read_value_o       (read_value),
        .search_valid_o     (search_valid),
        .search_index_o     (search_index),
        .search_multi_o     (search_multi),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic [W-1:0]  rval;
        logic          sv;
        logic [IW-1:0] si;
        logic          sm;
        logic          bz;
    } out_t;

    typedef struct {
        logic          we;
        logic [IW-1:0] wi;
        logic [W-1:0]  wd;
        logic          ie;
        logic [IW-1:0] ii;
        logic          re;
        logic [IW-1:0] ri;
        logic          se;
        logic [W-1:0]  sd;
        logic [W-1:0]  smk;
        out_t          exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain arrays of contents and valid flags, plus the
    // position of the flush sweep (-1 when no flush is running).
    logic [W-1:0] md [D];
    logic         mv [D];
    int           fpos = -1;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] key_mask();
`ifdef PARAM_CAM_TERNARY_EN
        return smk;
`else
        return '1;
`endif
    endfunction

    function automatic out_t model_eval();
        out_t o;
        int   n;
        logic bsy;
        o   = '{default: '0};
        bsy = (fpos >= 0);
        if (re && !bsy && mv[ri]) begin
            o.rv   = 1'b1;
            o.rval = md[ri];
        end
        if (se && !bsy) begin
            n = 0;
            for (int i = 0; i < D; i++) begin
                if (mv[i] && (((md[i] ^ sd) & key_mask()) == 0)) begin
                    if (n == 0) o.si = IW'(i);
                    n++;
                end
            end
            o.sv = (n > 0);
            o.sm = (n >= 2);
        end
        return o;
    endfunction

    task automatic model_update();
        if (fpos >= 0) begin
            mv[fpos] = 1'b0;
            fpos++;
            if (fpos == D) fpos = -1;
        end else begin
            if (ie) mv[ii] = 1'b0;
            if (we && !fl) begin
                md[wi] = wd;
                mv[wi] = 1'b1;
            end
            if (fl) fpos = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) mv[i] = 1'b0;
        fpos = -1;
    endtask

    // One clock: predict from pre-edge state, advance, sample #1 after edge.
    task automatic step(output out_t e);
        e = model_eval();
        @(posedge clk);
        #1;
        model_update();
        e.bz = (fpos >= 0);
    endtask

    task automatic check_outs(string tag, out_t e);
        chk({tag, ".read_valid"},   W'(read_valid),   W'(e.rv));
        chk({tag, ".read_value"},   read_value,       e.rval);
        chk({tag, ".search_valid"}, W'(search_valid), W'(e.sv));
        chk({tag, ".search_index"}, W'(search_index), W'(e.si));
        chk({tag, ".search_multi"}, W'(search_multi), W'(e.sm));
        chk({tag, ".busy"},         W'(busy),         W'(e.bz));
    endtask

    task automatic idle_inputs();
        re = 0; we = 0; ie = 0; se = 0; fl = 0;
        ri = '0; wi = '0; ii = '0;
        wd = '0; sd = '0; smk = '1;
    endtask

    function automatic vec_t mk(logic w, int wix, logic [W-1:0] wdat,
                                logic inv, int iix, logic r, int rix,
                                logic s, logic [W-1:0] key, logic [W-1:0] msk,
                                logic erv, logic [W-1:0] erval,
                                logic esv, int esi, logic esm);
        vec_t v;
        v.we = w;   v.wi = IW'(wix); v.wd = wdat;
        v.ie = inv; v.ii = IW'(iix);
        v.re = r;   v.ri = IW'(rix);
        v.se = s;   v.sd = key;      v.smk = msk;
        v.exp.rv = erv; v.exp.rval = erval;
        v.exp.sv = esv; v.exp.si = IW'(esi); v.exp.sm = esm; v.exp.bz = 1'b0;
        return v;
    endfunction

    vec_t         vecs [15];
    out_t         e;
    logic [W-1:0] fillv [D];
    int           busy_cnt;

    initial begin
        for (int i = 0; i < D; i++) begin
            md[i] = '0;
            mv[i] = 1'b0;
        end

        //            we wi wd            ie ii re ri se key           mask          rv rval          sv si sm
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 0, 1, 5, 0, 32'h0,        32'hFFFFFFFF, 1, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 3, 32'h1234,     0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[3]  = mk(1, 9, 32'h1234,     0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h1234,     32'hFFFFFFFF, 0, 32'h0,        1, 3, 1);
        vecs[5]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h1234,     32'hFFFFFFFF, 0, 32'h0,        1, 9, 0);
        vecs[7]  = mk(0, 0, 32'h0,        0, 0, 1, 3, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[8]  = mk(1, 7, 32'hABCD00FF, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
`ifdef PARAM_CAM_TERNARY_EN
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hABCD1234, 32'hFFFF0000, 0, 32'h0,        1, 7, 0);
`else
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hABCD1234, 32'hFFFF0000, 0, 32'h0,        0, 0, 0);
`endif
        vecs[10] = mk(1, 3, 32'h5555,     1, 3, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);
        vecs[11] = mk(0, 0, 32'h0,        0, 0, 1, 3, 0, 32'h0,        32'hFFFFFFFF, 1, 32'h5555,     0, 0, 0);
        vecs[12] = mk(1, 5, 32'h11111111, 0, 0, 1, 5, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 32'hDEADBEEF, 1, 5, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 1, 5, 0, 32'h0,        32'hFFFFFFFF, 1, 32'h11111111, 0, 0, 0);
        vecs[14] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e = '{default: '0};
        check_outs("reset", e);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed table
        for (int k = 0; k < 15; k++) begin
            we = vecs[k].we; wi = vecs[k].wi; wd = vecs[k].wd;
            ie = vecs[k].ie; ii = vecs[k].ii;
            re = vecs[k].re; ri = vecs[k].ri;
            se = vecs[k].se; sd = vecs[k].sd; smk = vecs[k].smk;
            fl = 1'b0;
            step(e);
            check_outs($sformatf("vec%0d", k), vecs[k].exp);
        end
        idle_inputs();

        // Full-table flush with a competing write, requests during the sweep
        for (int i = 0; i < D; i++) begin
            fillv[i] = $urandom;
            we = 1; wi = IW'(i); wd = fillv[i];
            step(e);
            check_outs("fill", e);
        end
        we = 1; wi = '0; wd = 32'hCAFEF00D; fl = 1;
        step(e);
        check_outs("flush_start", e);
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            we = 1; wi = IW'($urandom_range(D - 1)); wd = $urandom;
            re = 1; ri = IW'($urandom_range(D - 1));
            se = 1; sd = fillv[$urandom_range(D - 1)]; smk = '1;
            ie = 0;
            fl = (k == 5);
            step(e);
            check_outs("flush_busy", e);
            if (busy) busy_cnt++;
            else break;
        end
        chk("flush_busy_cycles", W'(busy_cnt), W'(D));
        idle_inputs();
        for (int i = 0; i < D; i++) begin
            se = 1; sd = fillv[i];
            step(e);
            check_outs("post_flush_search", e);
        end
        sd = 32'hCAFEF00D;
        step(e);
        chk("dropped_write_search", W'(search_valid), W'(0));
        idle_inputs();

        // Reset during a flush
        for (int i = 0; i < 4; i++) begin
            we = 1; wi = IW'(20 + i); wd = 32'h7000 + W'(i);
            step(e);
        end
        idle_inputs();
        fl = 1;
        step(e);
        fl = 0;
        for (int k = 0; k < 9; k++) step(e);
        chk("midflush_busy_before_rst", W'(busy), W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("midflush_rst_busy", W'(busy), W'(0));
        chk("midflush_rst_read_valid", W'(read_valid), W'(0));
        chk("midflush_rst_search_valid", W'(search_valid), W'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            re = 1; ri = IW'(i);
            step(e);
            check_outs("post_rst_read", e);
        end
        idle_inputs();
        we = 1; wi = '0; wd = 32'h0BADC0DE;
        step(e);
        idle_inputs();
        se = 1; sd = 32'h0BADC0DE;
        step(e);
        chk("post_rst_hit_valid", W'(search_valid), W'(1));
        chk("post_rst_hit_index", W'(search_index), W'(0));
        idle_inputs();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            we  = ($urandom_range(2) != 0);
            wi  = IW'($urandom_range(D - 1));
            wd  = ($urandom_range(1) != 0) ? W'($urandom_range(3)) << 8 : $urandom;
            ie  = ($urandom_range(4) == 0);
            ii  = IW'($urandom_range(D - 1));
            re  = ($urandom_range(1) != 0);
            ri  = IW'($urandom_range(D - 1));
            se  = ($urandom_range(1) != 0);
            sd  = md[$urandom_range(D - 1)];
            if ($urandom_range(3) == 0) sd = sd ^ (W'(1) << $urandom_range(W - 1));
            smk = ($urandom_range(1) != 0) ? '1 : $urandom;
            fl  = ($urandom_range(80) == 0);
            step(e);
            check_outs("rand", e);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, number of entries (power of two, 2..256).
REQ-003 Parameter IDX_W, default $clog2(DEPTH), index width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 read_enable_i  in  1  read request; read_index_i  in  IDX_W  entry to read.
REQ-007 write_enable_i  in  1  write request; write_index_i  in  IDX_W  entry; write_data_i  in  WIDTH  data.
REQ-008 invalidate_enable_i  in  1  clear one entry's valid bit; invalidate_index_i  in  IDX_W  entry.
REQ-009 flush_i  in  1  one-cycle pulse starting a full-table flush.
REQ-010 search_enable_i  in  1  search request; search_data_i  in  WIDTH  key; search_mask_i  in  WIDTH  per-bit compare enable (1 = compare).
REQ-011 read_valid_o  out  1  read_value_o holds a valid entry; read_value_o  out  WIDTH  read data.
REQ-012 search_valid_o  out  1  at least one hit; search_index_o  out  IDX_W  lowest hitting index.
REQ-013 search_multi_o  out  1  two or more entries hit; busy_o  out  1  flush in progress.

Function
REQ-014 Storage: DEPTH x WIDTH data array plus DEPTH valid bits.
REQ-015 Write: on edge with write_enable_i, entry write_index_i takes write_data_i and valid bit set.
REQ-016 Invalidate: on edge with invalidate_enable_i, valid bit of invalidate_index_i cleared; data unchanged.
REQ-017 Write and invalidate to the same index in the same cycle: write wins (entry valid).
REQ-018 Read: latency 1; cycle after read_enable_i, read_valid_o = entry valid bit, read_value_o = entry data if valid else 0.
REQ-019 No read_enable_i: read_valid_o = 0, read_value_o = 0 next cycle.
REQ-020 Search: latency 1, registered outputs; entry hits when valid and ((data XOR key) AND mask) == 0.
REQ-021 search_index_o = lowest hitting index (priority encode); 0 when search_valid_o = 0.
REQ-022 search_multi_o = 1 when hit count >= 2; 0 otherwise or when no search issued.
REQ-023 Same-cycle read/search versus write/invalidate: read and search observe pre-update contents.
REQ-024 Flush FSM states IDLE, FLUSH; IDLE->FLUSH on flush_i; FLUSH clears valid bit of counter entry each cycle, counter 0..DEPTH-1; FLUSH->IDLE after entry DEPTH-1 cleared.
REQ-025 busy_o = 1 exactly while in FLUSH (DEPTH cycles); flush_i in FLUSH ignored.
REQ-026 While busy_o = 1, write, invalidate, read and search requests are dropped; read/search outputs 0.
REQ-027 flush_i in the same cycle as a write: write dropped, flush starts.
REQ-028 Out-of-range indices (DEPTH not power of two excluded by REQ-002) cannot occur.

Reset
REQ-029 rst_i asserted: immediately all valid bits 0, FSM IDLE, flush counter 0, all outputs 0; data array need not be cleared.
REQ-030 Reset mid-flush: flush aborted, busy_o = 0 immediately, table empty.

Configuration
REQ-031 Macro PARAM_CAM_TERNARY_EN defined: search_mask_i applied per REQ-020.
REQ-032 Macro undefined: search_mask_i ignored, mask treated as all ones (exact-match binary CAM); port remains present.

Verification
REQ-033 Reset, write 0xDEADBEEF to index 5, read index 5 -> next cycle read_valid_o=1, read_value_o=0xDEADBEEF.
REQ-034 Write 0x1234 to indices 3 and 9, search 0x1234 mask all ones -> search_valid_o=1, search_index_o=3, search_multi_o=1.
REQ-035 Invalidate index 3, search 0x1234 -> search_index_o=9, search_multi_o=0; read index 3 -> read_valid_o=0, read_value_o=0.
REQ-036 With PARAM_CAM_TERNARY_EN: entry 7 = 0xABCD00FF, search 0xABCD1234 mask 0xFFFF0000 -> hit index 7; without macro -> search_valid_o=0.
REQ-037 Fill all entries, pulse flush_i -> busy_o high 32 cycles, writes dropped, afterwards every search misses.
REQ-038 Pulse flush_i, assert rst_i at flush cycle 10 -> busy_o=0 immediately, all entries invalid, new write then search at index 0 hits.
